// File: rtl/jelly2_data_logger_trigger.sv
// Arms on ctl_start, waits for a trigger, then emits a decimated, length-limited burst one cycle after each slot.
// The source is never stalled: a slot that finds the output register occupied is dropped and counted.
module jelly2_data_logger_trigger #(
    parameter int NUM         = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                      reset,
    input  logic                      clk,
    input  logic                      cke,

    input  logic                      ctl_start,
    input  logic                      ctl_stop,
    input  logic [1:0]                ctl_mode,
    input  logic [NUM*DATA_WIDTH-1:0] ctl_trig_mask,
    input  logic [NUM*DATA_WIDTH-1:0] ctl_trig_value,
    input  logic [COUNT_WIDTH-1:0]    ctl_decimation,
    input  logic [COUNT_WIDTH-1:0]    ctl_post_count,

    input  logic [NUM*DATA_WIDTH-1:0] s_data,
    input  logic                      s_valid,

    output logic [NUM*DATA_WIDTH-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,

    output logic [1:0]                stat_state,
    output logic [COUNT_WIDTH-1:0]    stat_sample_count,
    output logic [COUNT_WIDTH-1:0]    stat_drop_count
);

    localparam int W = NUM * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    logic [1:0]             state;
    logic [W-1:0]           prev_data;
    logic                   prev_valid;
    logic [COUNT_WIDTH-1:0] dec_cnt;

    logic                   trig;
    logic                   armed_hit;
    logic                   cap_slot;
    logic                   slot;
    logic                   out_free;
    logic [COUNT_WIDTH-1:0] sample_count_next;
    logic                   post_done;

    always_comb begin
        trig = 1'b0;
        case (ctl_mode)
            2'd0:    trig = 1'b1;
            2'd1:    trig = (((s_data ^ ctl_trig_value) & ctl_trig_mask) == '0);
            2'd2:    trig = prev_valid && (((s_data ^ prev_data) & ctl_trig_mask) != '0);
            default: trig = 1'b0;
        endcase
    end

    // ctl_stop suppresses any slot in the same cycle
    assign armed_hit         = (state == ST_ARMED)   && s_valid && trig && !ctl_stop;
    assign cap_slot          = (state == ST_CAPTURE) && s_valid && (dec_cnt == '0) && !ctl_stop;
    assign slot              = armed_hit || cap_slot;
    assign out_free          = !m_valid || m_ready;
    assign sample_count_next = stat_sample_count + 1'b1;
    assign post_done         = (ctl_post_count != '0) && (sample_count_next == ctl_post_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            prev_data         <= '0;
            prev_valid        <= 1'b0;
            dec_cnt           <= '0;
            m_data            <= '0;
            m_valid           <= 1'b0;
            stat_sample_count <= '0;
            stat_drop_count   <= '0;
        end else if (cke) begin
            if (s_valid) begin
                prev_data  <= s_data;
                prev_valid <= 1'b1;
            end

            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            if (slot) begin
                stat_sample_count <= sample_count_next;
                if (out_free) begin
                    m_data  <= s_data;
                    m_valid <= 1'b1;
                end else if (stat_drop_count != '1) begin
                    stat_drop_count <= stat_drop_count + 1'b1;
                end
            end

            if (ctl_stop) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ctl_start) begin
                            state             <= ST_ARMED;
                            stat_sample_count <= '0;
                            stat_drop_count   <= '0;
                            dec_cnt           <= '0;
                            prev_valid        <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (armed_hit) begin
                            dec_cnt <= ctl_decimation;
                            state   <= post_done ? ST_IDLE : ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (s_valid) begin
                            if (dec_cnt == '0) begin
                                dec_cnt <= ctl_decimation;
                                if (post_done) begin
                                    state <= ST_IDLE;
                                end
                            end else begin
                                dec_cnt <= dec_cnt - 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign stat_state = state;

endmodule
